// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - activation modes, per-lane activation and zero-lane popcount
package relu_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;
    localparam logic [1:0] MODE_CLIP   = 2'd3;

    // Lanes are sign-extended to ACT_W so one function serves any FW up to 32.
    localparam int ACT_W     = 32;
    localparam int ACT_SW    = 5;
    localparam int MAX_LANES = 64;
    localparam int CNT_W     = 7;

    typedef enum logic {
        FRAME_IDLE,
        FRAME_ACTIVE
    } frame_state_e;

    function automatic logic signed [ACT_W-1:0] act_lane(
        input logic signed [ACT_W-1:0]  x,
        input logic        [1:0]        mode,
        input logic        [ACT_SW-1:0] shift,
        input logic signed [ACT_W-1:0]  clip
    );
        logic signed [ACT_W-1:0] y;
        y = x;
        case (mode)
            MODE_BYPASS: y = x;
            MODE_RELU:   if (x < 0) y = '0;
            MODE_LEAKY:  if (x < 0) y = x >>> shift;
            MODE_CLIP: begin
                if (x < 0 || clip <= 0) y = '0;
                else if (x > clip)      y = clip;
            end
            default:     y = x;
        endcase
        return y;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] flags);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + CNT_W'(flags[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/relu_stream_unit_if.sv
// rtl/relu_stream_unit_if.sv - input and output beat handshake bundle
interface relu_stream_unit_if #(
    parameter int FW    = 16,
    parameter int LANES = 32
);
    logic                  data_valid_i;
    logic                  data_ready_o;
    logic [LANES*FW-1:0]   data_i;
    logic                  data_last_i;
    logic                  relu_valid_o;
    logic                  relu_ready_i;
    logic [LANES*FW-1:0]   relu_data_o;
    logic                  relu_last_o;

    modport slave (
        input  data_valid_i, data_i, data_last_i, relu_ready_i,
        output data_ready_o, relu_valid_o, relu_data_o, relu_last_o
    );

    modport master (
        output data_valid_i, data_i, data_last_i, relu_ready_i,
        input  data_ready_o, relu_valid_o, relu_data_o, relu_last_o
    );
endinterface

// File: rtl/relu_lane_act.sv
// rtl/relu_lane_act.sv - combinational activation of one signed lane
module relu_lane_act
    import relu_pkg::*;
#(
    parameter  int FW = 16,
    localparam int SW = $clog2(FW)
) (
    input  logic [FW-1:0] x_i,
    input  logic [1:0]    mode_i,
    input  logic [SW-1:0] shift_i,
    input  logic [FW-1:0] clip_i,
    output logic [FW-1:0] y_o
);

    // Results never exceed |x| or clip, so truncating back to FW is lossless.
    assign y_o = FW'(act_lane(ACT_W'($signed(x_i)), mode_i, ACT_SW'(shift_i),
                              ACT_W'($signed(clip_i))));

endmodule

// File: rtl/relu_stream_unit.sv
// rtl/relu_stream_unit.sv - two-stage activation pipeline with frame cfg latch and zero stats
module relu_stream_unit
    import relu_pkg::*;
#(
    parameter  int FW    = 16,
    parameter  int LANES = 32,
    parameter  int CW    = 32,
    localparam int SW    = $clog2(FW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_mode_i,
    input  logic [SW-1:0]       cfg_shift_i,
    input  logic [FW-1:0]       cfg_clip_i,
    relu_stream_unit_if.slave   bus,
    output logic [CW-1:0]       zero_cnt_o,
    output logic                stat_valid_o
);

    frame_state_e        state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic [FW-1:0]       clip_q, clip_d;

    logic [1:0]          act_mode;
    logic [SW-1:0]       act_shift;
    logic [FW-1:0]       act_clip;
    logic [LANES*FW-1:0] act_data;

    logic                s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [LANES*FW-1:0] s1_data_q, s1_data_d;
    logic                s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [LANES*FW-1:0] s2_data_q, s2_data_d;

    logic [CW-1:0]       acc_q, acc_d, zero_cnt_q, zero_cnt_d;
    logic                stat_valid_q, stat_valid_d;

    logic                s2_ready, in_fire, out_fire;
    logic [LANES-1:0]    zero_flags;
    logic [CNT_W-1:0]    zero_lanes;
    logic [CW:0]         sum_wide;
    logic [CW-1:0]       acc_sum;

    assign s2_ready          = !s2_valid_q || bus.relu_ready_i;
    assign bus.data_ready_o  = !s1_valid_q || s2_ready;
    assign in_fire           = bus.data_valid_i && bus.data_ready_o;
    assign out_fire          = s2_valid_q && bus.relu_ready_i;

    assign bus.relu_valid_o  = s2_valid_q;
    assign bus.relu_data_o   = s2_data_q;
    assign bus.relu_last_o   = s2_last_q;
    assign zero_cnt_o        = zero_cnt_q;
    assign stat_valid_o      = stat_valid_q;

    // The first beat of a frame sees the live cfg, later beats the latched copy.
    assign act_mode  = (state_q == FRAME_IDLE) ? cfg_mode_i  : mode_q;
    assign act_shift = (state_q == FRAME_IDLE) ? cfg_shift_i : shift_q;
    assign act_clip  = (state_q == FRAME_IDLE) ? cfg_clip_i  : clip_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_lane_act #(.FW(FW)) u_act (
            .x_i     (bus.data_i[i*FW +: FW]),
            .mode_i  (act_mode),
            .shift_i (act_shift),
            .clip_i  (act_clip),
            .y_o     (act_data[i*FW +: FW])
        );
        assign zero_flags[i] = (s2_data_q[i*FW +: FW] == '0);
    end

    assign zero_lanes = popcount(MAX_LANES'(zero_flags));
    assign sum_wide   = {1'b0, acc_q} + (CW+1)'(zero_lanes);
    assign acc_sum    = sum_wide[CW] ? '1 : sum_wide[CW-1:0];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        clip_d  = clip_q;
        if (in_fire) begin
            if (state_q == FRAME_IDLE) begin
                mode_d  = cfg_mode_i;
                shift_d = cfg_shift_i;
                clip_d  = cfg_clip_i;
            end
            state_d = bus.data_last_i ? FRAME_IDLE : FRAME_ACTIVE;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = act_data;
            s1_last_d  = bus.data_last_i;
        end else if (s2_ready) begin
            s1_valid_d = 1'b0;
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
                s2_last_d = s1_last_q;
            end
        end
    end

    always_comb begin
        acc_d        = acc_q;
        zero_cnt_d   = zero_cnt_q;
        stat_valid_d = 1'b0;
        if (out_fire) begin
            if (s2_last_q) begin
                zero_cnt_d   = acc_sum;
                stat_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d        = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FRAME_IDLE;
            mode_q       <= MODE_BYPASS;
            shift_q      <= '0;
            clip_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_last_q    <= 1'b0;
            acc_q        <= '0;
            zero_cnt_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            shift_q      <= shift_d;
            clip_q       <= clip_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_last_q    <= s2_last_d;
            acc_q        <= acc_d;
            zero_cnt_q   <= zero_cnt_d;
            stat_valid_q <= stat_valid_d;
        end
    end

endmodule

// File: tb/tb_relu_stream_unit.sv
// tb/tb_relu_stream_unit.sv - directed self-checking bench for relu_stream_unit
module tb_relu_stream_unit;

    localparam int FW    = 16;
    localparam int LANES = 4;
    localparam int CW    = 32;
    localparam int SW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic [SW-1:0] cfg_shift;
    logic [FW-1:0] cfg_clip;
    logic [CW-1:0] zero_cnt;
    logic          stat_valid;

    int checks = 0;
    int errors = 0;

    logic [64:0]   got_q[$];
    logic [CW-1:0] stat_q[$];
    logic          hold_pend = 1'b0;
    logic [64:0]   hold_val  = '0;
    int            cycles;

    relu_stream_unit_if #(.FW(FW), .LANES(LANES)) bus ();

    relu_stream_unit #(.FW(FW), .LANES(LANES), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mode_i   (cfg_mode),
        .cfg_shift_i  (cfg_shift),
        .cfg_clip_i   (cfg_clip),
        .bus          (bus),
        .zero_cnt_o   (zero_cnt),
        .stat_valid_o (stat_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] n(input int v);
        return 16'(v);
    endfunction

    function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] stream_beat(input int j);
        case (j)
            100:     return pk(n(0), n(0), n(0), n(0));
            101:     return pk(n(1), n(0), n(2), n(3));
            102:     return pk(n(0), n(5), n(0), n(0));
            default: return pk(n(j), n(32'h1000 + j), n(-j), (j % 4 == 0) ? 16'h0 : n(j));
        endcase
    endfunction

    function automatic logic stream_last(input int j);
        return (j == 99) || (j == 102);
    endfunction

    // Outputs and stat pulses are recorded at the falling edge, where handshakes are settled.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (bus.relu_valid_o && bus.relu_ready_i)
                got_q.push_back({bus.relu_last_o, bus.relu_data_o});
            if (stat_valid)
                stat_q.push_back(zero_cnt);
            if (hold_pend)
                chk("hold_stable", {bus.relu_valid_o, bus.relu_last_o, bus.relu_data_o}, {1'b1, hold_val});
            hold_pend <= bus.relu_valid_o && !bus.relu_ready_i;
            hold_val  <= {bus.relu_last_o, bus.relu_data_o};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last);
        int  k;
        logic acc;
        k = 0;
        acc = 1'b0;
        bus.data_valid_i = 1'b1;
        bus.data_i       = d;
        bus.data_last_i  = last;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = bus.data_ready_o;
            step();
            k++;
        end
        bus.data_valid_i = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(input int cnt);
        int k;
        k = 0;
        while (got_q.size() < cnt && k < 50) begin
            step();
            k++;
        end
        chk("out_count", got_q.size(), cnt);
    endtask

    task automatic pop_chk(input string tag, input logic [64:0] exp);
        logic [64:0] v;
        v = 'x;
        if (got_q.size() > 0) v = got_q.pop_front();
        chk(tag, v, exp);
    endtask

    task automatic stat_chk(input string tag, input logic [CW-1:0] exp);
        logic [CW-1:0] v;
        int k;
        k = 0;
        while (stat_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        v = 'x;
        if (stat_q.size() > 0) v = stat_q.pop_front();
        chk(tag, v, exp);
    endtask

    task automatic run_stream(input int nbeats, input bit rand_ready, output int cyc);
        int idx;
        idx = 0;
        cyc = 0;
        bus.data_valid_i = 1'b1;
        while (idx < nbeats && cyc < 2000) begin
            bus.data_i       = stream_beat(idx);
            bus.data_last_i  = stream_last(idx);
            bus.relu_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.data_ready_o) idx++;
            step();
            cyc++;
        end
        bus.data_valid_i = 1'b0;
        bus.relu_ready_i = 1'b1;
        chk("stream_sent", idx, nbeats);
        wait_out(nbeats);
        for (int j = 0; j < nbeats; j++) begin
            pop_chk("stream_order", {stream_last(j), stream_beat(j)});
        end
    endtask

    initial begin
        rst              = 1'b1;
        cfg_mode         = 2'd0;
        cfg_shift        = '0;
        cfg_clip         = '0;
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
        bus.data_last_i  = 1'b0;
        bus.relu_ready_i = 1'b1;
        repeat (3) step();
        chk("rst_valid", bus.relu_valid_o, 0);
        chk("rst_data", bus.relu_data_o, 0);
        chk("rst_last", bus.relu_last_o, 0);
        chk("rst_zero_cnt", zero_cnt, 0);
        chk("rst_stat", stat_valid, 0);
        chk("rst_ready", bus.data_ready_o, 1);
        rst = 1'b0;
        step();

        // Fill the pipeline under stall, then reset mid-frame.
        bus.relu_ready_i = 1'b0;
        bus.data_valid_i = 1'b1;
        bus.data_last_i  = 1'b0;
        bus.data_i       = pk(n(1), n(2), n(3), n(4));
        step();
        bus.data_i       = pk(n(5), n(6), n(7), n(8));
        step();
        bus.data_valid_i = 1'b0;
        step();
        chk("stall_valid", bus.relu_valid_o, 1);
        chk("stall_ready", bus.data_ready_o, 0);
        rst = 1'b1;
        repeat (3) step();
        chk("midrst_valid", bus.relu_valid_o, 0);
        chk("midrst_zero_cnt", zero_cnt, 0);
        chk("midrst_stat", stat_valid, 0);
        rst = 1'b0;
        bus.relu_ready_i = 1'b1;
        repeat (6) step();
        chk("flushed_out", got_q.size(), 0);

        // ReLU single-beat frame with exact latency.
        cfg_mode         = 2'd1;
        bus.data_i       = pk(n(-1), n(0), n(5), 16'h8000);
        bus.data_last_i  = 1'b1;
        bus.data_valid_i = 1'b1;
        step();
        bus.data_valid_i = 1'b0;
        chk("lat_cycle1", bus.relu_valid_o, 0);
        step();
        chk("lat_cycle2", bus.relu_valid_o, 1);
        chk("relu_data", bus.relu_data_o, pk(n(0), n(0), n(5), n(0)));
        chk("relu_last", bus.relu_last_o, 1);
        step();
        chk("relu_stat", stat_valid, 1);
        chk("relu_zero_cnt", zero_cnt, 3);
        chk("relu_drained", bus.relu_valid_o, 0);
        step();
        chk("relu_stat_pulse", stat_valid, 0);
        got_q.delete();
        stat_q.delete();

        cfg_mode  = 2'd2;
        cfg_shift = 4'd2;
        send_beat(pk(n(-8), n(-1), n(7), 16'h8000), 1'b1);
        wait_out(1);
        pop_chk("leaky_s2", {1'b1, pk(n(-2), n(-1), n(7), 16'hE000)});
        stat_chk("leaky_s2_zero", 0);
        cfg_shift = 4'd0;
        send_beat(pk(n(-5), n(3), 16'h8000, n(-1)), 1'b1);
        wait_out(1);
        pop_chk("leaky_s0", {1'b1, pk(n(-5), n(3), 16'h8000, n(-1))});
        stat_chk("leaky_s0_zero", 0);

        cfg_mode = 2'd3;
        cfg_clip = n(6);
        send_beat(pk(n(-3), n(4), n(9), n(6)), 1'b1);
        wait_out(1);
        pop_chk("clip6", {1'b1, pk(n(0), n(4), n(6), n(6))});
        stat_chk("clip6_zero", 1);
        cfg_clip = n(-1);
        send_beat(pk(n(5), n(-5), 16'h7FFF, n(0)), 1'b1);
        wait_out(1);
        pop_chk("clip_neg", {1'b1, pk(n(0), n(0), n(0), n(0))});
        stat_chk("clip_neg_zero", 4);
        cfg_clip = 16'h7FFF;
        send_beat(pk(16'h8000, 16'h7FFF, n(1), n(-1)), 1'b1);
        wait_out(1);
        pop_chk("clip_max", {1'b1, pk(n(0), 16'h7FFF, n(1), n(0))});
        stat_chk("clip_max_zero", 2);

        // Mode changes mid-frame must not take effect until the next frame.
        cfg_mode = 2'd1;
        send_beat(pk(n(-1), n(2), n(-3), n(4)), 1'b0);
        cfg_mode = 2'd0;
        send_beat(pk(n(-7), n(0), n(8), n(-9)), 1'b0);
        send_beat(pk(16'h8000, n(1), n(-1), n(-2)), 1'b0);
        send_beat(pk(n(3), n(-3), n(3), n(-3)), 1'b1);
        wait_out(4);
        pop_chk("latch_b0", {1'b0, pk(n(0), n(2), n(0), n(4))});
        pop_chk("latch_b1", {1'b0, pk(n(0), n(0), n(8), n(0))});
        pop_chk("latch_b2", {1'b0, pk(n(0), n(1), n(0), n(0))});
        pop_chk("latch_b3", {1'b1, pk(n(3), n(0), n(3), n(0))});
        stat_chk("latch_zero", 10);
        send_beat(pk(n(-4), n(4), n(0), n(-1)), 1'b1);
        wait_out(1);
        pop_chk("next_bypass", {1'b1, pk(n(-4), n(4), n(0), n(-1))});
        stat_chk("next_zero", 1);

        run_stream(100, 1'b1, cycles);
        stat_chk("bp_zero", 27);
        chk("bp_stat_count", stat_q.size(), 0);

        run_stream(103, 1'b0, cycles);
        chk("full_rate_cycles", cycles, 103);
        stat_chk("b2b_frame_a", 27);
        stat_chk("b2b_frame_b", 8);
        repeat (3) step();
        chk("b2b_stat_count", stat_q.size(), 0);
        chk("final_out_count", got_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
